fmap_maxpool_col: RTL and testbench

FMAP_MAXPOOL_COL -- requirements
Module: fmap_maxpool_col

---
 rtl/fmap_maxpool_col.sv | 92 +++++++++
 tb/tb_fmap_maxpool_col.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_maxpool_col.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fmap_maxpool_col
// Purpose  : Column-streaming 2x2 stride-2 signed max-pool for a conv feature map.
// Revision : 1.0
// ============================================================================
module fmap_maxpool_col #(
  parameter int DATA_WIDTH = 16,
  parameter int PIX_H      = 24,
  parameter int PIX_W      = 24,
  localparam int IDX_W     = (PIX_W > 2) ? $clog2(PIX_W / 2) : 1
) (
  input  logic                         out_stream_aclk,
  input  logic                         periph_resetn,
  input  logic                         start,
  input  logic                         valid_col,
  input  logic signed [DATA_WIDTH-1:0] data_col [PIX_H],
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] pool_col [PIX_H/2],
  output logic [IDX_W-1:0]             out_col_idx,
  output logic                         frame_done
);

  localparam int C_HALF_H = PIX_H / 2;
  localparam int C_COL_W  = (PIX_W > 1) ? $clog2(PIX_W) : 1;

  generate
    if (PIX_H == 0 || (PIX_H % 2) != 0) begin : g_bad_pix_h
      $error("fmap_maxpool_col: PIX_H must be a nonzero even value");
    end
    if (PIX_W == 0 || (PIX_W % 2) != 0) begin : g_bad_pix_w
      $error("fmap_maxpool_col: PIX_W must be a nonzero even value");
    end
  endgenerate

  logic [C_COL_W-1:0]           r_in_col;
  logic signed [DATA_WIDTH-1:0] r_buf      [C_HALF_H];
  logic signed [DATA_WIDTH-1:0] w_pair_max [C_HALF_H];
  logic signed [DATA_WIDTH-1:0] w_pool     [C_HALF_H];
  logic [C_COL_W-1:0]           w_col;
  logic                         w_last;

  // start re-aligns the incoming column to position 0 in the same cycle.
  assign w_col  = start ? '0 : r_in_col;
  assign w_last = (w_col == C_COL_W'(PIX_W - 1));

  always_comb begin
    for (int r = 0; r < C_HALF_H; r++) begin
      w_pair_max[r] = (data_col[2*r] > data_col[2*r+1]) ? data_col[2*r] : data_col[2*r+1];
      w_pool[r]     = (r_buf[r] > w_pair_max[r]) ? r_buf[r] : w_pair_max[r];
    end
  end

  always_ff @(posedge out_stream_aclk) begin
    if (!periph_resetn) begin
      r_in_col    <= '0;
      valid_out   <= 1'b0;
      frame_done  <= 1'b0;
      out_col_idx <= '0;
      for (int r = 0; r < C_HALF_H; r++) begin
        r_buf[r]    <= '0;
        pool_col[r] <= '0;
      end
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_col) begin
        r_in_col <= w_last ? '0 : w_col + 1'b1;
        if (!w_col[0]) begin
          for (int r = 0; r < C_HALF_H; r++) begin
            r_buf[r] <= w_pair_max[r];
          end
        end else begin
          for (int r = 0; r < C_HALF_H; r++) begin
            pool_col[r] <= w_pool[r];
          end
          valid_out   <= 1'b1;
          out_col_idx <= IDX_W'(w_col >> 1);
          frame_done  <= w_last;
        end
      end else if (start) begin
        r_in_col <= '0;
        for (int r = 0; r < C_HALF_H; r++) begin
          r_buf[r] <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fmap_maxpool_col.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fmap_maxpool_col
// Purpose  : Scoreboard bench for fmap_maxpool_col against a column-level model.
// Revision : 1.0
// ============================================================================
module tb_fmap_maxpool_col;

  localparam int DW = 16;
  localparam int PH = 24;
  localparam int PW = 24;
  localparam int HH = PH / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 resetn;
  logic                 start;
  logic                 valid_col;
  logic signed [DW-1:0] data_col [PH];
  logic                 valid_out;
  logic signed [DW-1:0] pool_col [HH];
  logic [3:0]           out_col_idx;
  logic                 frame_done;

  fmap_maxpool_col #(.DATA_WIDTH(DW), .PIX_H(PH), .PIX_W(PW)) dut (
    .out_stream_aclk (clk),
    .periph_resetn   (resetn),
    .start           (start),
    .valid_col       (valid_col),
    .data_col        (data_col),
    .valid_out       (valid_out),
    .pool_col        (pool_col),
    .out_col_idx     (out_col_idx),
    .frame_done      (frame_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int n_vout = 0;
  int n_fd   = 0;
  bit mon_en = 1'b0;

  // Reference model state: column position and the stored even column.
  int                   m_col = 0;
  logic signed [DW-1:0] col_v  [PH];
  logic signed [DW-1:0] m_even [PH];

  int              q_idx  [$];
  bit              q_fd   [$];
  int              q_cyc  [$];
  logic [HH*DW-1:0] q_pool [$];
  logic [HH*DW-1:0] last_pool = '0;
  int               last_idx  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [HH*DW-1:0] dut_pool_flat();
    logic [HH*DW-1:0] f;
    for (int r = 0; r < HH; r++) f[r*DW +: DW] = pool_col[r];
    return f;
  endfunction

  task automatic fill_ramp(input int c);
    for (int r = 0; r < PH; r++) col_v[r] = DW'(r * 24 + c);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < PH; r++) col_v[r] = DW'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents col_v for one cycle and records what the model expects from it.
  task automatic send_col(input bit st);
    logic [HH*DW-1:0] e;
    valid_col = 1'b1;
    start     = st;
    for (int i = 0; i < PH; i++) data_col[i] = col_v[i];
    if (st) m_col = 0;
    if ((m_col % 2) == 0) begin
      for (int i = 0; i < PH; i++) m_even[i] = col_v[i];
    end else begin
      for (int r = 0; r < HH; r++)
        e[r*DW +: DW] = smax(smax(m_even[2*r], m_even[2*r+1]), smax(col_v[2*r], col_v[2*r+1]));
      q_pool.push_back(e);
      q_idx.push_back(m_col / 2);
      q_fd.push_back(m_col == PW - 1);
      q_cyc.push_back(cyc + 1);
    end
    m_col = (m_col + 1) % PW;
    @(posedge clk);
    #1;
    valid_col = 1'b0;
    start     = 1'b0;
  endtask

  // Reset with a live column and start presented, both of which must be dropped.
  task automatic do_reset(input int n);
    mon_en = 1'b0;
    resetn = 1'b0;
    fill_rand();
    for (int i = 0; i < PH; i++) data_col[i] = col_v[i];
    valid_col = 1'b1;
    start     = 1'b1;
    idle(n);
    valid_col = 1'b0;
    start     = 1'b0;
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_out_col_idx", int'(out_col_idx), 0);
    checks++;
    if (dut_pool_flat() !== '0) begin
      errors++;
      $display("FAIL rst_pool_col: got %h, expected 0", dut_pool_flat());
    end
    resetn    = 1'b1;
    m_col     = 0;
    last_pool = '0;
    last_idx  = 0;
    mon_en    = 1'b1;
  endtask

  task automatic phase_end(input string name, input int v0, input int f0,
                           input int exp_v, input int exp_fd);
    idle(3);
    check({name, "_pending"}, q_idx.size(), 0);
    check({name, "_valid_out_count"}, n_vout - v0, exp_v);
    check({name, "_frame_done_count"}, n_fd - f0, exp_fd);
    q_idx.delete(); q_fd.delete(); q_cyc.delete(); q_pool.delete();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_out) begin
        n_vout++;
        if (frame_done) n_fd++;
        if (q_idx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid_out: got idx %0d, expected no output (cycle %0d)",
                   out_col_idx, cyc);
        end else begin
          logic [HH*DW-1:0] ep;
          int ei, ec;
          bit ef;
          ep = q_pool.pop_front();
          ei = q_idx.pop_front();
          ef = q_fd.pop_front();
          ec = q_cyc.pop_front();
          check("out_col_idx", int'(out_col_idx), ei);
          check("frame_done", int'(frame_done), int'(ef));
          check("latency_cycle", cyc, ec);
          checks++;
          if (dut_pool_flat() !== ep) begin
            errors++;
            for (int r = 0; r < HH; r++)
              if (pool_col[r] !== ep[r*DW +: DW])
                $display("FAIL pool_col[%0d] idx %0d: got %0d, expected %0d",
                         r, ei, pool_col[r], $signed(ep[r*DW +: DW]));
          end
          last_pool = ep;
          last_idx  = ei;
        end
      end else begin
        check("idle_frame_done", int'(frame_done), 0);
        check("hold_out_col_idx", int'(out_col_idx), last_idx);
        checks++;
        if (dut_pool_flat() !== last_pool) begin
          errors++;
          $display("FAIL hold_pool_col: got %h, expected %h", dut_pool_flat(), last_pool);
        end
      end
    end
  end

  initial begin
    int v0, f0;
    resetn    = 1'b0;
    start     = 1'b0;
    valid_col = 1'b0;
    for (int i = 0; i < PH; i++) data_col[i] = '0;
    do_reset(3);

    // Ramp frame, continuous columns.
    v0 = n_vout; f0 = n_fd;
    for (int c = 0; c < PW; c++) begin
      fill_ramp(c);
      send_col(1'b0);
    end
    phase_end("ramp", v0, f0, 12, 1);

    // Signed corner values in rows 0/1, then random rest of frame with gaps.
    v0 = n_vout; f0 = n_fd;
    fill_rand();
    col_v[0] = -16'sd5;
    col_v[1] = -16'sd3;
    send_col(1'b0);
    fill_rand();
    col_v[0] = -16'sd7;
    col_v[1] = 16'sh8000;
    send_col(1'b0);
    check("signed_pool0", int'(pool_col[0]), -3);
    for (int c = 2; c < PW; c++) begin
      idle($urandom_range(0, 5));
      fill_rand();
      send_col(1'b0);
    end
    phase_end("signed", v0, f0, 12, 1);

    // Ramp frame with random gaps.
    v0 = n_vout; f0 = n_fd;
    for (int c = 0; c < PW; c++) begin
      idle($urandom_range(0, 5));
      fill_ramp(c);
      send_col(1'b0);
    end
    phase_end("gaps", v0, f0, 12, 1);

    // start coincident with the 7th column aborts the frame.
    v0 = n_vout; f0 = n_fd;
    for (int c = 0; c < 6; c++) begin
      fill_ramp(c);
      send_col(1'b0);
    end
    fill_ramp(6);
    send_col(1'b1);
    for (int c = 1; c < PW; c++) begin
      fill_ramp(c + 6);
      send_col(1'b0);
    end
    phase_end("start", v0, f0, 15, 1);

    // Reset on the cycle after the 5th column.
    v0 = n_vout; f0 = n_fd;
    for (int c = 0; c < 5; c++) begin
      fill_ramp(c);
      send_col(1'b0);
    end
    do_reset(1);
    phase_end("reset_abort", v0, f0, 2, 0);
    v0 = n_vout; f0 = n_fd;
    for (int c = 0; c < PW; c++) begin
      fill_ramp(c);
      send_col(1'b0);
    end
    phase_end("after_reset", v0, f0, 12, 1);

    // Two random frames back-to-back without idle cycles.
    v0 = n_vout; f0 = n_fd;
    for (int c = 0; c < 2 * PW; c++) begin
      fill_rand();
      send_col(1'b0);
    end
    phase_end("b2b", v0, f0, 24, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
